// File: rtl/dual_slope_sequencer.sv
// -----------------------------------------------------------------------------
// dual_slope_sequencer
//
// Phase controller for a dual-slope integrating voltmeter. A conversion runs
// three analog phases in order:
//   AZ    : auto-zero switch closed for AZ_CYCLES clocks
//   INT   : Vin integrate switch closed for INT_CYCLES clocks
//   DEINT : Vref de-integrate switch closed until the comparator reports the
//           integrator is back at zero, or until MAX_DEINT clocks elapse
// followed by a single DONE cycle that publishes the count.
//
// Ports:
//   clk_i            system clock
//   rst_n_i          asynchronous active-low reset
//   start_i          conversion request, looked at only in IDLE
//   abort_i          synchronous abort from AZ/INT/DEINT back to IDLE
//   comp_i           asynchronous comparator, 1 = integrator not yet at zero
//   az_en_o          auto-zero switch enable
//   int_en_o         Vin integrate switch enable
//   deint_en_o       Vref de-integrate switch enable
//   busy_o           high in every state except IDLE
//   result_o         last completed de-integrate count, held until the next
//   overflow_o       last conversion hit the de-integrate timeout
//   valid_o          one-cycle pulse, result_o/overflow_o updated this cycle
//   measurement_en_o one-cycle pulse coincident with valid_o
//   state_o          current FSM state, for debug and checker binding
//
// Handshake: valid_o is a push-only strobe with no back-pressure. It is high
// for exactly one cycle per completed conversion, and result_o/overflow_o are
// stable from that cycle until the next valid_o. An aborted or reset
// conversion never produces valid_o.
// -----------------------------------------------------------------------------
module dual_slope_sequencer #(
    parameter int CNT_W      = 12,
    parameter int AZ_CYCLES  = 256,
    parameter int INT_CYCLES = 2048,
    parameter int MAX_DEINT  = 4095
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             comp_i,
    output logic             az_en_o,
    output logic             int_en_o,
    output logic             deint_en_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] result_o,
    output logic             overflow_o,
    output logic             valid_o,
    output logic             measurement_en_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AZ    = 3'd1,
        S_INT   = 3'd2,
        S_DEINT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // One phase counter serves all three timed phases. It must be wide
    // enough for the longest fixed phase and for the de-integrate count.
    localparam int AI_MAX = (AZ_CYCLES > INT_CYCLES) ? AZ_CYCLES : INT_CYCLES;
    localparam int AI_W   = $clog2(AI_MAX + 1);
    localparam int PH_W   = (AI_W > CNT_W) ? AI_W : CNT_W;

    localparam logic [PH_W-1:0]  AZ_LAST    = PH_W'(AZ_CYCLES - 1);
    localparam logic [PH_W-1:0]  INT_LAST   = PH_W'(INT_CYCLES - 1);
    localparam logic [PH_W-1:0]  DEINT_LAST = PH_W'(MAX_DEINT);
    localparam logic [CNT_W-1:0] DEINT_SAT  = CNT_W'(MAX_DEINT);

    state_t          state;
    logic [PH_W-1:0] phase_cnt;
    logic [1:0]      comp_sync;
    logic            comp_s;

    // Two-flop synchronizer for the comparator. The two-clock lag shows up
    // as a +2 bias in result_o; the downstream scaling absorbs it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            comp_sync <= 2'b00;
        end else begin
            comp_sync <= {comp_sync[0], comp_i};
        end
    end

    assign comp_s  = comp_sync[1];
    assign state_o = state;

    // Main FSM. Every output is written here alongside the next state, so
    // each output is a registered function of the state it belongs to.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state            <= S_IDLE;
            phase_cnt        <= '0;
            az_en_o          <= 1'b0;
            int_en_o         <= 1'b0;
            deint_en_o       <= 1'b0;
            busy_o           <= 1'b0;
            result_o         <= '0;
            overflow_o       <= 1'b0;
            valid_o          <= 1'b0;
            measurement_en_o <= 1'b0;
        end else begin
            // Strobes default low; only the DEINT exit raises them.
            valid_o          <= 1'b0;
            measurement_en_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state     <= S_AZ;
                        phase_cnt <= '0;
                        az_en_o   <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end

                S_AZ: begin
                    // Abort wins over a phase that is completing this cycle.
                    if (abort_i) begin
                        state     <= S_IDLE;
                        phase_cnt <= '0;
                        az_en_o   <= 1'b0;
                        busy_o    <= 1'b0;
                    end else if (phase_cnt == AZ_LAST) begin
                        state     <= S_INT;
                        phase_cnt <= '0;
                        az_en_o   <= 1'b0;
                        int_en_o  <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                S_INT: begin
                    if (abort_i) begin
                        state     <= S_IDLE;
                        phase_cnt <= '0;
                        int_en_o  <= 1'b0;
                        busy_o    <= 1'b0;
                    end else if (phase_cnt == INT_LAST) begin
                        state      <= S_DEINT;
                        phase_cnt  <= '0;
                        int_en_o   <= 1'b0;
                        deint_en_o <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                S_DEINT: begin
                    // phase_cnt equals the number of completed DEINT cycles,
                    // so a comparator already low on entry yields 0.
                    if (abort_i) begin
                        state      <= S_IDLE;
                        phase_cnt  <= '0;
                        deint_en_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end else if (!comp_s) begin
                        state            <= S_DONE;
                        deint_en_o       <= 1'b0;
                        result_o         <= phase_cnt[CNT_W-1:0];
                        overflow_o       <= 1'b0;
                        valid_o          <= 1'b1;
                        measurement_en_o <= 1'b1;
                    end else if (phase_cnt == DEINT_LAST) begin
                        // Timeout: the counter saturates here and never wraps.
                        state            <= S_DONE;
                        deint_en_o       <= 1'b0;
                        result_o         <= DEINT_SAT;
                        overflow_o       <= 1'b1;
                        valid_o          <= 1'b1;
                        measurement_en_o <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    // Always exactly one cycle; abort has nothing to cancel.
                    state     <= S_IDLE;
                    phase_cnt <= '0;
                    busy_o    <= 1'b0;
                end

                default: begin
                    state      <= S_IDLE;
                    phase_cnt  <= '0;
                    az_en_o    <= 1'b0;
                    int_en_o   <= 1'b0;
                    deint_en_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

    // The analog switches must never be commanded closed together.
    a_switch_excl: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        $onehot0({az_en_o, int_en_o, deint_en_o})
    );

    // valid_o and measurement_en_o are the same event seen by two consumers.
    a_strobe_pair: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        valid_o == measurement_en_o
    );

endmodule

// File: tb/tb_dual_slope_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for dual_slope_sequencer with short phases
// (AZ_CYCLES=4, INT_CYCLES=8, MAX_DEINT=20).
//
// Timeline convention: the edge that samples start_i in IDLE is edge 0, and
// "cycle n" is the clock period after edge n-1. Directed checks are taken on
// the falling edge inside cycle n. A DEINT index k means cycle 13+k, where
// the de-integrate counter holds k. Dropping comp_i during DEINT index k
// gives result k+2 because of the two-flop synchronizer.
// -----------------------------------------------------------------------------
module tb_dual_slope_sequencer;

    localparam int CNT_W      = 12;
    localparam int AZ_CYCLES  = 4;
    localparam int INT_CYCLES = 8;
    localparam int MAX_DEINT  = 20;

    // ---------------- clock / reset ----------------
    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             start_i;
    logic             abort_i;
    logic             comp_i;
    logic             az_en_o;
    logic             int_en_o;
    logic             deint_en_o;
    logic             busy_o;
    logic [CNT_W-1:0] result_o;
    logic             overflow_o;
    logic             valid_o;
    logic             measurement_en_o;
    logic [2:0]       state_o;

    dual_slope_sequencer #(
        .CNT_W     (CNT_W),
        .AZ_CYCLES (AZ_CYCLES),
        .INT_CYCLES(INT_CYCLES),
        .MAX_DEINT (MAX_DEINT)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .comp_i          (comp_i),
        .az_en_o         (az_en_o),
        .int_en_o        (int_en_o),
        .deint_en_o      (deint_en_o),
        .busy_o          (busy_o),
        .result_o        (result_o),
        .overflow_o      (overflow_o),
        .valid_o         (valid_o),
        .measurement_en_o(measurement_en_o),
        .state_o         (state_o)
    );

    // ---------------- scoreboard state ----------------
    logic [CNT_W:0] exp_q[$];   // {overflow, result}
    int n_checks = 0;
    int n_fail   = 0;
    int meas_cnt = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (busy_o)
                check("switch_excl", 32'(az_en_o) + 32'(int_en_o) + 32'(deint_en_o) <= 1, 1);
            if (valid_o || measurement_en_o) begin
                check("meas_eq_valid", measurement_en_o, valid_o);
                if (measurement_en_o)
                    meas_cnt++;
                if (valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        logic [CNT_W:0] e;
                        e = exp_q.pop_front();
                        check("sb_result", result_o, e[CNT_W-1:0]);
                        check("sb_overflow", overflow_o, e[CNT_W]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step_to(input int target);
        while (cyc < target) begin
            @(negedge clk_i);
            cyc++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Called on a falling edge while IDLE; returns on the falling edge of cycle 1.
    task automatic start_conv();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        start_i = 1'b0;
        abort_i = 1'b0;
        comp_i  = 1'b1;

        idle(3);
        check("rst_state", state_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_az", az_en_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_result", result_o, 0);
        rst_n_i = 1'b1;
        idle(3);

        // Nominal: comp drops at DEINT index 5 -> result 7.
        exp_q.push_back({1'b0, 12'd7});
        start_conv();
        check("nom_az_c1", az_en_o, 1);
        check("nom_busy_c1", busy_o, 1);
        step_to(4);  check("nom_az_c4", az_en_o, 1);
        step_to(5);  check("nom_az_c5", az_en_o, 0);
                     check("nom_int_c5", int_en_o, 1);
        step_to(12); check("nom_int_c12", int_en_o, 1);
        step_to(13); check("nom_int_c13", int_en_o, 0);
                     check("nom_deint_c13", deint_en_o, 1);
        step_to(18); comp_i = 1'b0;
        step_to(20); check("nom_deint_c20", deint_en_o, 1);
                     check("nom_valid_c20", valid_o, 0);
        step_to(21); check("nom_valid_c21", valid_o, 1);
                     check("nom_deint_c21", deint_en_o, 0);
                     check("nom_busy_c21", busy_o, 1);
        step_to(22); check("nom_busy_c22", busy_o, 0);
                     check("nom_valid_c22", valid_o, 0);
        comp_i = 1'b1;
        idle(3);

        // Abort during INT: idle next cycle, result kept.
        start_conv();
        step_to(7);  check("abt_int_c7", int_en_o, 1);
        abort_i = 1'b1;
        step_to(8);  abort_i = 1'b0;
                     check("abt_int_c8", int_en_o, 0);
                     check("abt_az_c8", az_en_o, 0);
                     check("abt_deint_c8", deint_en_o, 0);
                     check("abt_busy_c8", busy_o, 0);
                     check("abt_result", result_o, 7);
        step_to(10); check("abt_busy_c10", busy_o, 0);
                     check("abt_meas_cnt", meas_cnt, 1);
        idle(2);

        // Timeout: comp stays high, 21 DEINT cycles.
        exp_q.push_back({1'b1, 12'd20});
        start_conv();
        step_to(13); check("to_deint_c13", deint_en_o, 1);
        step_to(33); check("to_deint_c33", deint_en_o, 1);
                     check("to_valid_c33", valid_o, 0);
        step_to(34); check("to_valid_c34", valid_o, 1);
                     check("to_deint_c34", deint_en_o, 0);
        step_to(35); check("to_busy_c35", busy_o, 0);
                     check("to_result_held", result_o, 20);
                     check("to_overflow_held", overflow_o, 1);
        idle(2);

        // Immediate trip plus a start during INT that must be ignored.
        comp_i = 1'b0;
        idle(3);
        exp_q.push_back({1'b0, 12'd0});
        start_conv();
        step_to(6);  check("ign_int_c6", int_en_o, 1);
        start_i = 1'b1;
        step_to(7);  start_i = 1'b0;
        step_to(13); check("ign_deint_c13", deint_en_o, 1);
        step_to(14); check("ign_valid_c14", valid_o, 1);
        step_to(15); check("ign_busy_c15", busy_o, 0);
        step_to(20); check("ign_busy_c20", busy_o, 0);
                     check("ign_az_c20", az_en_o, 0);
                     check("ign_overflow", overflow_o, 0);
        comp_i = 1'b1;
        idle(3);

        // Back-to-back with start held: DONE c19, IDLE c20, AZ c21.
        exp_q.push_back({1'b0, 12'd5});
        exp_q.push_back({1'b0, 12'd5});
        start_i = 1'b1;
        @(negedge clk_i);
        cyc = 1;
        check("b2b_az_c1", az_en_o, 1);
        step_to(16); comp_i = 1'b0;
        step_to(19); check("b2b_valid_c19", valid_o, 1);
        comp_i = 1'b1;
        step_to(20); check("b2b_busy_c20", busy_o, 0);
                     check("b2b_az_c20", az_en_o, 0);
        step_to(21); check("b2b_az_c21", az_en_o, 1);
        step_to(33); check("b2b_deint_c33", deint_en_o, 1);
        step_to(36); comp_i = 1'b0;
        step_to(39); check("b2b_valid_c39", valid_o, 1);
        start_i = 1'b0;
        comp_i  = 1'b1;
        step_to(40); check("b2b_busy_c40", busy_o, 0);
        step_to(42); check("b2b_busy_c42", busy_o, 0);
                     check("b2b_meas_cnt", meas_cnt, 5);
        idle(2);

        // Reset asserted mid-DEINT, then a clean restart.
        start_conv();
        step_to(15); check("rm_deint_c15", deint_en_o, 1);
        #1 rst_n_i = 1'b0;
        #1;
        check("rm_deint", deint_en_o, 0);
        check("rm_busy", busy_o, 0);
        check("rm_state", state_o, 0);
        check("rm_result", result_o, 0);
        check("rm_overflow", overflow_o, 0);
        check("rm_valid", valid_o, 0);
        idle(2);
        rst_n_i = 1'b1;
        idle(2);
        exp_q.push_back({1'b0, 12'd2});
        start_conv();
        check("rs_az_c1", az_en_o, 1);
        step_to(4);  check("rs_az_c4", az_en_o, 1);
                     check("rs_int_c4", int_en_o, 0);
        step_to(5);  check("rs_int_c5", int_en_o, 1);
        step_to(13); check("rs_deint_c13", deint_en_o, 1);
        comp_i = 1'b0;
        step_to(15); check("rs_valid_c15", valid_o, 0);
        step_to(16); check("rs_valid_c16", valid_o, 1);
        comp_i = 1'b1;
        idle(3);

        check("sb_queue_empty", exp_q.size(), 0);
        check("meas_total", meas_cnt, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
